// File: rtl/leosoc_spi_pkg.sv
// Shared definitions for the SPI pad-group arbiter: FSM states and default timing.
package leosoc_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        NEXT,
        RELEASE
    } arb_state_e;

    localparam int DEFAULT_HALF   = 2;
    localparam int DEFAULT_CS_GAP = 4;

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 byte serialiser: MSB first, sdi sampled as sck rises, sdo updated as sck falls.
module spi_byte_shifter #(
    parameter int HALF = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       sdi_i,
    output logic       sck_o,
    output logic       sdo_o,
    output logic       done_o,
    output logic [7:0] rx_o
);

    localparam int HW = $clog2(HALF + 1);

    logic          active_q;
    logic          sck_q;
    logic          sdo_q;
    logic          done_q;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;
    logic [HW-1:0] hcnt_q;
    logic [2:0]    bit_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            sdo_q    <= 1'b0;
            done_q   <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            hcnt_q   <= '0;
            bit_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                // bit 7 is on sdo for the whole setup half-period
                active_q <= 1'b1;
                tx_q     <= data_i;
                sdo_q    <= data_i[7];
                sck_q    <= 1'b0;
                hcnt_q   <= '0;
                bit_q    <= '0;
            end else if (active_q) begin
                if (hcnt_q == HW'(HALF - 1)) begin
                    hcnt_q <= '0;
                    sck_q  <= ~sck_q;
                    if (!sck_q) begin
                        rx_q <= {rx_q[6:0], sdi_i};
                    end else begin
                        tx_q  <= {tx_q[6:0], 1'b0};
                        sdo_q <= tx_q[6];
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end else begin
                    hcnt_q <= hcnt_q + HW'(1);
                end
            end
        end
    end

    assign sck_o  = sck_q;
    assign sdo_o  = sdo_q;
    assign done_o = done_q;
    assign rx_o   = rx_q;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the SPI pad group; cs stays low across the owner's whole transaction.
module spi_bus_arbiter
    import leosoc_spi_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int HALF   = DEFAULT_HALF,
    parameter int CS_GAP = DEFAULT_CS_GAP
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              busy,
    output logic              sck,
    output logic              sdo,
    input  logic              sdi,
    output logic              cs
);

    localparam int PW = $clog2(NREQ);
    localparam int GW = $clog2(CS_GAP + 1);

    arb_state_e    state_q;
    logic [PW-1:0] p_q;
    logic [PW-1:0] owner_q;
    logic          last_q;
    logic          cs_q;
    logic [GW-1:0] gap_q;

    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   sel_idx;
    logic [NREQ-1:0] own_oh;
    logic            own_take;
    logic            accept;
    logic            sh_done;
    logic            sh_sck;
    logic [7:0]      sh_rx;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && req_valid[(int'(p_q) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'((int'(p_q) + k) % NREQ);
            end
        end
    end

    assign own_oh = NREQ'(1) << owner_q;
    // the response cycle doubles as acceptance of the owner's next byte
    assign own_take = req_valid[owner_q] &&
                      (state_q == NEXT || (state_q == SHIFT && sh_done && !last_q));

    always_comb begin
        req_ready = '0;
        if (reset_n) begin
            if (state_q == IDLE && gnt_found)
                req_ready = NREQ'(1) << gnt_idx;
            else if (own_take)
                req_ready = own_oh;
        end
    end

    assign accept  = |req_ready;
    assign sel_idx = (state_q == IDLE) ? gnt_idx : owner_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            owner_q <= '0;
            last_q  <= 1'b0;
            cs_q    <= 1'b1;
            gap_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    owner_q <= gnt_idx;
                    p_q     <= PW'((int'(gnt_idx) + 1) % NREQ);
                    last_q  <= req_last[gnt_idx];
                    cs_q    <= 1'b0;
                    state_q <= SETUP;
                end
                SETUP: if (sh_sck) state_q <= SHIFT;
                SHIFT: if (sh_done) begin
                    if (last_q) begin
                        cs_q    <= 1'b1;
                        gap_q   <= '0;
                        state_q <= RELEASE;
                    end else if (accept) begin
                        last_q  <= req_last[owner_q];
                        state_q <= SETUP;
                    end else begin
                        state_q <= NEXT;
                    end
                end
                NEXT: if (accept) begin
                    last_q  <= req_last[owner_q];
                    state_q <= SETUP;
                end
                RELEASE: begin
                    if (gap_q == GW'(CS_GAP - 1)) state_q <= IDLE;
                    else                          gap_q   <= gap_q + GW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    spi_byte_shifter #(.HALF(HALF)) u_shifter (
        .clk     (clk),
        .reset_n (reset_n),
        .start_i (accept),
        .data_i  (req_data[{sel_idx, 3'b000} +: 8]),
        .sdi_i   (sdi),
        .sck_o   (sh_sck),
        .sdo_o   (sdo),
        .done_o  (sh_done),
        .rx_o    (sh_rx)
    );

    assign rsp_valid = sh_done ? own_oh : '0;
    assign rsp_data  = sh_rx;
    assign sck       = sh_sck;
    assign cs        = cs_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with NREQ=2, HALF=2, CS_GAP=4.
module tb_spi_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_last = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        busy, sck, sdo, cs, sdi;
    logic        lb = 1'b0;
    logic        sdi_ext = 1'b0;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rises = 0;
    logic        prev_sck = 1'b0;
    logic [1:0]  rr_acc = '0;
    logic [1:0]  rsp_acc = '0;
    logic        cs_hi_acc = 1'b0;

    assign sdi = lb ? sdo : sdi_ext;

    always #5 clk = ~clk;

    spi_bus_arbiter #(.NREQ(2), .HALF(2), .CS_GAP(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .sck       (sck),
        .sdo       (sdo),
        .sdi       (sdi),
        .cs        (cs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rr_acc  |= req_ready;
        rsp_acc |= rsp_valid;
        if (cs) cs_hi_acc = 1'b1;
        if (sck && !prev_sck) rises++;
        prev_sck = sck;
    endtask

    task automatic go(input int c);
        while (cyc < c) tick();
    endtask

    task automatic mark();
        cyc = 0; rises = 0; rr_acc = '0; rsp_acc = '0; cs_hi_acc = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = '0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        tick(); tick();
        check("rst cs", cs, 1);
        check("rst sck", sck, 0);
        check("rst sdo", sdo, 0);
        check("rst req_ready", req_ready, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_data", rsp_data, 0);
        check("rst busy", busy, 0);
        reset_n = 1'b1;
        tick();

        // single byte, loopback
        lb = 1'b1;
        req_data = 16'h00A5; req_last = 2'b01; req_valid = 2'b01;
        #1; mark();
        check("t1 accept", req_ready, 2'b01);
        tick(); req_valid = '0;
        check("t1 cs low c1", cs, 0);
        check("t1 busy c1", busy, 1);
        go(2);  check("t1 sck c2", sck, 0);
        go(3);  check("t1 sck rise c3", sck, 1);
        go(32); check("t1 no early rsp", rsp_valid, 0);
        go(33);
        check("t1 rsp_valid", rsp_valid, 2'b01);
        check("t1 rsp_data", rsp_data, 8'hA5);
        check("t1 sck pulses", rises, 8);
        check("t1 cs held", cs_hi_acc, 0);
        go(34); check("t1 cs rise", cs, 1);
        check("t1 rsp one cycle", rsp_valid, 0);
        go(37); check("t1 busy in gap", busy, 1);
        go(38); check("t1 idle busy", busy, 0);

        // simultaneous requests, external sdi=1
        do_reset();
        lb = 1'b0; sdi_ext = 1'b1;
        req_data = 16'hC33C; req_last = 2'b11; req_valid = 2'b11;
        #1; mark();
        check("t2 grant r0", req_ready, 2'b01);
        tick(); req_valid = 2'b10;
        go(33);
        check("t2 rsp r0", rsp_valid, 2'b01);
        check("t2 data r0", rsp_data, 8'hFF);
        go(34); rr_acc = '0;
        go(37); check("t2 no grant in gap", rr_acc, 0);
        go(38); check("t2 grant r1", req_ready, 2'b10);
        mark(); tick(); req_valid = '0;
        go(33);
        check("t2 rsp r1", rsp_valid, 2'b10);
        check("t2 data r1", rsp_data, 8'hFF);

        // fairness
        do_reset();
        req_last = 2'b11; req_valid = 2'b11;
        #1;
        for (int t = 0; t < 4; t++) begin
            int n;
            n = 0;
            while (req_ready == 2'b00 && n < 100) begin tick(); n++; end
            check("fair grant", req_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        req_valid = '0;

        // multi-byte lock, loopback
        do_reset();
        lb = 1'b1;
        req_data = 16'h12EE; req_last = 2'b01; req_valid = 2'b10;
        #1; mark();
        check("t4 grant r1", req_ready, 2'b10);
        tick(); req_valid = 2'b11; req_data[15:8] = 8'h34;
        go(33);
        check("t4 rsp b0", rsp_valid, 2'b10);
        check("t4 data b0", rsp_data, 8'h12);
        check("t4 accept with rsp", req_ready, 2'b10);
        tick(); req_data[15:8] = 8'h56; req_last[1] = 1'b1;
        go(66);
        check("t4 data b1", rsp_data, 8'h34);
        check("t4 accept b2", req_ready, 2'b10);
        tick(); req_valid[1] = 1'b0;
        go(99);
        check("t4 rsp b2", rsp_valid, 2'b10);
        check("t4 data b2", rsp_data, 8'h56);
        check("t4 cs held", cs_hi_acc, 0);
        check("t4 r0 locked out", rr_acc[0], 0);
        go(100); check("t4 cs release", cs, 1);
        go(104); check("t4 r0 after release", req_ready, 2'b01);
        req_valid = '0;

        // owner stall
        do_reset();
        req_data = 16'h9A00; req_last = 2'b01; req_valid = 2'b10;
        #1; mark();
        tick(); req_valid = 2'b01;
        go(33); check("t5 data b0", rsp_data, 8'h9A);
        go(34); mark();
        go(100);
        check("t5 cs held", cs_hi_acc, 0);
        check("t5 no sck", rises, 0);
        check("t5 sck low", sck, 0);
        check("t5 busy", busy, 1);
        check("t5 no r0 grant", rr_acc, 0);
        req_valid = 2'b11; req_last = 2'b11;
        #1; check("t5 resume r1", req_ready, 2'b10);
        tick(); req_valid = '0;

        // reset mid-byte
        do_reset();
        req_data = 16'h005A; req_last = 2'b01; req_valid = 2'b01;
        #1; mark();
        tick(); req_valid = '0;
        go(12);
        check("t6 sck high after 3rd rise", sck, 1);
        check("t6 rises before reset", rises, 3);
        reset_n = 1'b0; req_valid = 2'b01;
        #1;
        check("t6 cs", cs, 1);
        check("t6 sck", sck, 0);
        check("t6 busy", busy, 0);
        check("t6 req_ready", req_ready, 0);
        check("t6 rsp_valid", rsp_valid, 0);
        mark();
        tick(); tick(); tick();
        req_valid = '0; reset_n = 1'b1;
        go(50);
        check("t6 no rsp after reset", rsp_acc, 0);
        check("t6 cs idle", cs, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Shares the single SPI pad group (sck, sdo, sdi, cs on io[8:5]) between NREQ on-chip requesters, for example the CPU SPI peripheral and a boot/flash loader inside leosoc. The block arbitrates round-robin at transaction granularity and serialises bytes in SPI mode 0, MSB first. It keeps cs asserted for the whole multi-byte transaction of the current owner.

## Interface
Parameters:
- NREQ, 2: number of requesters (2..4)
- HALF, 2: SPI half-period in clk cycles (≥1)
- CS_GAP, 4: minimum clk cycles cs stays high between transactions (≥1)

Ports:
- clk  in  1  system clock; the only clock
- reset_n  in  1  reset, asynchronous and active-low
- req_valid  in  NREQ  requester i presents a byte
- req_data  in  8*NREQ  byte of requester i in bits [8i+7:8i]
- req_last  in  NREQ  byte is the last one of the transaction
- req_ready  out  NREQ  one-cycle accept strobe per requester
- rsp_valid  out  NREQ  one-cycle strobe: received byte available for requester i
- rsp_data  out  8  received byte; valid only while a rsp_valid bit is high
- busy  out  1  high from grant until the release gap completes
- sck  out  1  SPI clock; idles low
- sdo  out  1  SPI data out
- sdi  in  1  SPI data in
- cs  out  1  chip select, active-low

## Operation
- States:
  - IDLE: no owner; arbitrates each cycle.
  - SETUP: cs low, sdo = bit7, sck low for HALF cycles.
  - SHIFT: 8 sck periods.
  - NEXT: owner holds the bus and cs stays low; waits for the owner's next byte.
  - RELEASE: cs high for CS_GAP cycles, then back to IDLE.
- Arbitration in IDLE is round-robin:
  - Search starts at pointer p and takes the first i with req_valid[i] set.
  - That requester receives req_ready[i] and becomes owner. The byte is latched and last_q = req_last[i]. Next state is SETUP.
  - Pointer becomes p = owner+1 mod NREQ. It resets to 0.
- Mode 0 shifting:
  - sck rises after each low half-period, and sdi is sampled into the shift register on that rising edge.
  - On the falling edge sdo takes the next bit.
- After the 8th falling edge:
  - rsp_valid[owner] pulses one cycle, with rsp_data = sampled byte.
  - If last_q is set, go to RELEASE.
  - Otherwise go to NEXT.
- NREQ and req_valid:
  - In NEXT, only the owner may be accepted. Acceptance is req_ready[owner] in the same cycle as req_valid[owner], after which the block goes to SETUP.
  - If the owner stalls, cs stays low and sck stays low indefinitely. There is no timeout.
  - Other requesters' req_valid is ignored until the block returns to IDLE.
- The rsp_valid cycle can double as NEXT acceptance: if req_valid[owner] is already high, req_ready[owner] is asserted in that same cycle.
- At most one req_ready bit is high in any cycle, and at most one rsp_valid bit.
- Requester data is only sampled on acceptance. Changes to req_data afterwards have no effect.

## Timing
- Reset values:
  - cs=1, sck=0, sdo=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, busy=0.
  - State IDLE, p=0.
- reset_n low at any point, including mid-byte, forces these values immediately. The transaction is dropped with no rsp_valid.
- Latency, with accept at cycle 0:
  - cs falls at cycle 1.
  - The k-th rising sck edge (k=0..7) comes at cycle 1+HALF*(2k+1).
  - sck falls for the last time and rsp_valid pulses at cycle 1+16*HALF. For HALF=2 that is cycle 33.
- After the last byte:
  - cs rises at cycle 2+16*HALF and stays high for CS_GAP cycles.
  - IDLE, with busy=0, follows that gap.
  - The earliest next req_ready is in the first IDLE cycle.
- Back-to-back bytes within a transaction: with the owner's byte already valid, the next cs-low SETUP starts the cycle after rsp_valid. Throughput is one byte per 16*HALF+1 cycles.

## Structure
- Shared package leosoc_spi_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, NEXT, RELEASE)
  - the default HALF and CS_GAP constants
- One sub-module, spi_byte_shifter, contains:
  - the half-period counter, bit counter and shift register
  - a start/done handshake
  - the sck, sdo and sdi handling
- The arbiter top contains the FSM, the round-robin pointer, ownership, and the cs/release timing.

## Test plan
- Single byte, loopback (sdi tied to sdo), HALF=2: requester 0 sends 0xA5 with last=1. Required response:
  - cs low over cycles 1..33
  - 8 sck pulses
  - rsp_valid[0] at cycle 33 with rsp_data=0xA5
  - cs high at cycle 34 for 4 cycles
- Simultaneous requests after reset, both valid with last=1, external sdi=1:
  - requester 0 granted first and receives 0xFF
  - requester 1 granted in the first IDLE cycle after the gap
- Fairness: requester 0 keeps issuing one-byte transactions while requester 1 is also valid. Required: grants alternate 0,1,0,1.
- Multi-byte lock:
  - requester 1 sends 0x12, 0x34, 0x56 with last only on 0x56, while requester 0 is valid throughout
  - cs stays low across all three bytes and requester 0 gets no grant
  - second accept coincides with the first rsp_valid
- Owner stall: requester 1 withholds its second byte for 100 cycles. Required: cs stays low, sck low, busy=1, and no req_ready to requester 0.
- Reset mid-byte: assert reset_n low after the 3rd sck rise. Required: cs=1, sck=0, busy=0 and all strobes 0 immediately, with no rsp_valid.
